axil_sram_slave: RTL and testbench

//  AXI4-Lite responder backed by a word-organised SRAM array, the memory end of the LSU/IFU master port.

---
 rtl/axil_sram_slave.sv | 198 +++++++++++++++++++
 tb/tb_axil_sram_slave.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave backed by a word-organised SRAM array with programmable
// read/write latency; read and write channels run as independent FSMs.
module axil_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned READ_LAT    = 2,
    parameter int unsigned WRITE_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [33:0] SPAN  = 34'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic addr_ok(input logic [31:0] a);
        logic [32:0] off;
        off = 33'(a) - 33'(BASE_ADDR);
        return (off[32] == 1'b0) && (34'(off) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // ---------------- read channel ----------------
    r_state_t    r_state, r_next;
    logic [7:0]  rcnt;
    logic [31:0] raddr_q;
    logic [31:0] rd_addr;
    logic        ar_hs;
    logic        r_load;

    always_comb begin
        r_next  = r_state;
        ar_hs   = arvalid && arready;
        rd_addr = (r_state == R_IDLE) ? araddr : raddr_q;
        case (r_state)
            R_IDLE: if (ar_hs) r_next = (READ_LAT == 0) ? R_RESP : R_WAIT;
            R_WAIT: if (rcnt == 8'd1) r_next = R_RESP;
            R_RESP: if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        r_load = (r_next == R_RESP) && (r_state != R_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            rcnt    <= '0;
            raddr_q <= '0;
        end else begin
            r_state <= r_next;
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        raddr_q <= araddr;
                        rcnt    <= 8'(READ_LAT);
                        arready <= 1'b0;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_WAIT: rcnt <= rcnt - 8'd1;
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Sampled on the commit edge too, so a same-word collision returns old data.
            if (r_load) begin
                rvalid <= 1'b1;
                rresp  <= addr_ok(rd_addr) ? 2'b00 : 2'b11;
                rdata  <= addr_ok(rd_addr) ? mem[addr_idx(rd_addr)] : '0;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state, w_next;
    logic [7:0]  wcnt;
    logic [31:0] waddr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_got, w_got;
    logic        aw_hs, w_hs, have_both;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic        w_commit;

    always_comb begin
        w_next    = w_state;
        aw_hs     = awvalid && awready;
        w_hs      = wvalid && wready;
        have_both = (aw_got || aw_hs) && (w_got || w_hs);
        // Zero-latency writes commit on the capture edge, so bypass the latches.
        wr_addr   = aw_got ? waddr_q : awaddr;
        wr_data   = w_got  ? wdata_q : wdata;
        wr_strb   = w_got  ? wstrb_q : wstrb;
        case (w_state)
            W_IDLE: if (have_both) w_next = (WRITE_LAT == 0) ? W_RESP : W_WAIT;
            W_WAIT: if (wcnt == 8'd1) w_next = W_RESP;
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
        w_commit = (w_next == W_RESP) && (w_state != W_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= '0;
            wcnt    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
        end else begin
            w_state <= w_next;
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        waddr_q <= awaddr;
                        aw_got  <= 1'b1;
                        awready <= 1'b0;
                    end else if (!aw_got) begin
                        awready <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        w_got   <= 1'b1;
                        wready  <= 1'b0;
                    end else if (!w_got) begin
                        wready <= 1'b1;
                    end
                    if (have_both) wcnt <= 8'(WRITE_LAT);
                end
                W_WAIT: wcnt <= wcnt - 8'd1;
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (w_commit) begin
                bvalid <= 1'b1;
                bresp  <= addr_ok(wr_addr) ? 2'b00 : 2'b11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_commit && addr_ok(wr_addr)) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[addr_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed bench for axil_sram_slave: vector table for single transactions
// plus hand sequences for ordering, backpressure, collision, reset and zero latency.
module tb_axil_sram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    logic        b_rst, b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
    logic        b_arvalid, b_arready, b_rvalid, b_rready;
    logic [31:0] b_awaddr, b_wdata, b_araddr, b_rdata;
    logic [3:0]  b_wstrb;
    logic [1:0]  b_bresp, b_rresp;

    axil_sram_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .READ_LAT(2), .WRITE_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    axil_sram_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .READ_LAT(0), .WRITE_LAT(0)) dut_z (
        .clk(clk), .rst(b_rst),
        .awvalid(b_awvalid), .awready(b_awready), .awaddr(b_awaddr),
        .wvalid(b_wvalid), .wready(b_wready), .wdata(b_wdata), .wstrb(b_wstrb),
        .bvalid(b_bvalid), .bready(b_bready), .bresp(b_bresp),
        .arvalid(b_arvalid), .arready(b_arready), .araddr(b_araddr),
        .rvalid(b_rvalid), .rready(b_rready), .rdata(b_rdata), .rresp(b_rresp)
    );

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                logic [31:0] ed, logic [1:0] er, string nm);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s;
        v.exp_data = ed; v.exp_resp = er; v.name = nm;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        int  n;
        logic a_hs, d_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            a_hs = awvalid && awready;
            d_hs = wvalid && wready;
            step();
            n++;
            if (a_hs) awvalid = 1'b0;
            if (d_hs) wvalid = 1'b0;
        end
        if (awvalid || wvalid) begin
            check("write_handshake_timeout", 32'd1, 32'd0);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        lat = 1;
        while (!bvalid && lat < 50) begin
            step();
            lat++;
        end
        resp = bresp;
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        int n;
        araddr = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            step();
            n++;
        end
        step();
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin
            step();
            lat++;
        end
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        int          lat, n;
        logic        seen;

        rst = 1'b1; b_rst = 1'b1;
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        {b_awvalid, b_wvalid, b_bready, b_arvalid, b_rready} = '0;
        b_awaddr = '0; b_wdata = '0; b_wstrb = '0; b_araddr = '0;

        repeat (3) step();
        check("reset_flags", {27'd0, arready, awready, wready, rvalid, bvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_resp", {28'd0, rresp, bresp}, 32'd0);
        rst = 1'b0; b_rst = 1'b0;
        step();
        check("ready_after_reset", {29'd0, arready, awready, wready}, 32'd7);

        vecs.push_back(mk(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00, "w_rw"));
        vecs.push_back(mk(0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, "r_rw"));
        vecs.push_back(mk(1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         2'b00, "w_init"));
        vecs.push_back(mk(1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         2'b00, "w_strb"));
        vecs.push_back(mk(0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00, "r_strb"));
        vecs.push_back(mk(1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00, "w_nostrb"));
        vecs.push_back(mk(0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00, "r_nostrb"));
        vecs.push_back(mk(1, 32'h8000_0000, 32'h0102_0304, 4'hF, 32'h0,         2'b00, "w_word0"));
        vecs.push_back(mk(1, 32'h9000_0000, 32'h1234_5678, 4'hF, 32'h0,         2'b11, "w_decerr"));
        vecs.push_back(mk(0, 32'h8000_0000, 32'h0,         4'h0, 32'h0102_0304, 2'b00, "r_word0"));
        vecs.push_back(mk(0, 32'h0000_0100, 32'h0,         4'h0, 32'h0,         2'b11, "r_decerr"));
        vecs.push_back(mk(1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00, "w_last"));
        vecs.push_back(mk(0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00, "r_last"));
        vecs.push_back(mk(0, 32'h8000_1000, 32'h0,         4'h0, 32'h0,         2'b11, "r_past_end"));
        vecs.push_back(mk(0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b11, "r_below_base"));
        vecs.push_back(mk(0, 32'h8000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, "r_unaligned"));
        vecs.push_back(mk(1, 32'h8000_0FFC, 32'h0000_00EE, 4'h1, 32'h0,         2'b00, "w_byte0"));
        vecs.push_back(mk(0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hCAFE_F0EE, 2'b00, "r_byte0"));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
                check({vecs[i].name, "_bresp"}, 32'(resp), 32'(vecs[i].exp_resp));
                check({vecs[i].name, "_blat"}, 32'(lat), 32'd3);
            end else begin
                do_read(vecs[i].addr, d, resp, lat);
                check({vecs[i].name, "_rdata"}, d, vecs[i].exp_data);
                check({vecs[i].name, "_rresp"}, 32'(resp), 32'(vecs[i].exp_resp));
                check({vecs[i].name, "_rlat"}, 32'(lat), 32'd3);
            end
        end

        // W three cycles ahead of AW
        awaddr = 32'h8000_0030; wdata = 32'h55AA_55AA; wstrb = 4'hF;
        wvalid = 1'b1;
        check("order_wready", {31'd0, wready}, 32'd1);
        step();
        wvalid = 1'b0;
        check("order_wready_low", {31'd0, wready}, 32'd0);
        check("order_no_bvalid1", {31'd0, bvalid}, 32'd0);
        step();
        check("order_no_bvalid2", {31'd0, bvalid}, 32'd0);
        step();
        awvalid = 1'b1;
        check("order_awready", {31'd0, awready}, 32'd1);
        step();
        awvalid = 1'b0;
        lat = 1;
        while (!bvalid && lat < 50) begin step(); lat++; end
        check("order_blat", 32'(lat), 32'd3);
        check("order_bresp", 32'(bresp), 32'd0);
        bready = 1'b1; step(); bready = 1'b0;
        do_read(32'h8000_0030, d, resp, lat);
        check("order_readback", d, 32'h55AA_55AA);

        // read backpressure
        do_write(32'h8000_0040, 32'hA5A5_5A5A, 4'hF, resp, lat);
        araddr = 32'h8000_0040; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin step(); n++; end
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin step(); n++; end
        for (int k = 0; k < 5; k++) begin
            check("bp_rvalid", {31'd0, rvalid}, 32'd1);
            check("bp_rdata", rdata, 32'hA5A5_5A5A);
            check("bp_arready", {31'd0, arready}, 32'd0);
            step();
        end
        rready = 1'b1; step(); rready = 1'b0;
        check("bp_rvalid_drop", {31'd0, rvalid}, 32'd0);
        check("bp_arready_back", {31'd0, arready}, 32'd1);

        // read sample and write commit on the same edge
        do_write(32'h8000_0050, 32'h0BAD_0BAD, 4'hF, resp, lat);
        araddr = 32'h8000_0050; awaddr = 32'h8000_0050;
        wdata = 32'h600D_F00D; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        check("coll_readies", {29'd0, arready, awready, wready}, 32'd7);
        step();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin step(); lat++; end
        check("coll_rlat", 32'(lat), 32'd3);
        check("coll_bvalid", {31'd0, bvalid}, 32'd1);
        check("coll_old_data", rdata, 32'h0BAD_0BAD);
        rready = 1'b1; bready = 1'b1; step(); rready = 1'b0; bready = 1'b0;
        do_read(32'h8000_0050, d, resp, lat);
        check("coll_new_data", d, 32'h600D_F00D);

        // reset while both FSMs wait; the pending write is dropped
        do_write(32'h8000_0060, 32'h1357_2468, 4'hF, resp, lat);
        araddr = 32'h8000_0060; awaddr = 32'h8000_0060;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        step();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_flags", {27'd0, arready, awready, wready, rvalid, bvalid}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            seen = seen | rvalid | bvalid;
        end
        check("rst_mid_no_valid", {31'd0, seen}, 32'd0);
        check("rst_mid_readies", {29'd0, arready, awready, wready}, 32'd7);
        do_read(32'h8000_0060, d, resp, lat);
        check("rst_mid_discard", d, 32'h1357_2468);

        // zero-latency instance
        b_awaddr = 32'h8000_0070; b_wdata = 32'h0F0F_0F0F; b_wstrb = 4'hF;
        b_awvalid = 1'b1; b_wvalid = 1'b1;
        check("z_readies", {29'd0, b_arready, b_awready, b_wready}, 32'd7);
        step();
        b_awvalid = 1'b0; b_wvalid = 1'b0;
        check("z_bvalid_lat1", {31'd0, b_bvalid}, 32'd1);
        check("z_bresp", 32'(b_bresp), 32'd0);
        b_bready = 1'b1; step(); b_bready = 1'b0;
        check("z_bvalid_drop", {31'd0, b_bvalid}, 32'd0);
        b_araddr = 32'h8000_0070; b_arvalid = 1'b1;
        step();
        b_arvalid = 1'b0;
        check("z_rvalid_lat1", {31'd0, b_rvalid}, 32'd1);
        check("z_rdata", b_rdata, 32'h0F0F_0F0F);
        check("z_arready_low", {31'd0, b_arready}, 32'd0);
        b_rready = 1'b1; step(); b_rready = 1'b0;
        check("z_arready_back", {31'd0, b_arready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
